// File: rtl/nrs_gold_seq_gen.sv
// Length-31 Gold sequence generator for the NB-IoT NRS chain. Each run fast-forwards
// NC + skip_offset steps, then writes WIDTH_REG bits c(n) into the NRS bit register.
module nrs_gold_seq_gen #(
    parameter int unsigned WIDTH_REG = 16,
    parameter int unsigned LINES     = $clog2(WIDTH_REG),
    parameter int unsigned NC        = 1600,
    parameter int unsigned OFS_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [30:0]      c_init,
    input  logic [OFS_W-1:0] skip_offset,
    output logic             c_n,
    output logic             wr_en,
    output logic [LINES-1:0] wr_addr,
    output logic             busy,
    output logic             done
);

    // Sized so NC plus the largest skip_offset never wraps.
    localparam int unsigned CNT_W = $clog2(NC + (2 ** OFS_W));
    localparam logic [LINES-1:0] LAST_ADDR = LINES'(WIDTH_REG - 1);

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        GEN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [30:0]        x1;
    logic [30:0]        x2;
    logic [CNT_W-1:0]   skip_cnt;
    logic [CNT_W-1:0]   load_cnt_c;
    logic [30:0]        x1_step_c;
    logic [30:0]        x2_step_c;

    assign load_cnt_c = CNT_W'(NC) + CNT_W'(skip_offset);
    assign x1_step_c  = {x1[3] ^ x1[0], x1[30:1]};
    assign x2_step_c  = {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[30:1]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (load_cnt_c == '0) ? GEN : WARMUP;
                end
            end
            WARMUP: begin
                if (skip_cnt == CNT_W'(1)) begin
                    state_nxt = GEN;
                end
            end
            GEN: begin
                if (wr_addr == LAST_ADDR) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // LFSRs, warm-up counter and write address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1       <= '0;
            x2       <= '0;
            skip_cnt <= '0;
            wr_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wr_addr <= '0;
                    if (start) begin
                        x1       <= 31'd1;
                        x2       <= c_init;
                        skip_cnt <= load_cnt_c;
                    end
                end
                WARMUP: begin
                    x1       <= x1_step_c;
                    x2       <= x2_step_c;
                    skip_cnt <= skip_cnt - CNT_W'(1);
                end
                GEN: begin
                    x1      <= x1_step_c;
                    x2      <= x2_step_c;
                    wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + LINES'(1);
                end
                default: begin
                    wr_addr <= '0;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register
    assign wr_en = (state == GEN);
    assign c_n   = wr_en & (x1[0] ^ x2[0]);
    assign busy  = (state == WARMUP) || (state == GEN);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_nrs_gold_seq_gen.sv
// Directed bench for nrs_gold_seq_gen: default build plus an NC=0 build, with an
// in-bench reference of the 36.211 Gold sequence recurrence.
module tb_nrs_gold_seq_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start_z;
    logic [30:0] c_init;
    logic [10:0] skip;

    logic        c_n, wr_en, busy, done;
    logic [3:0]  wr_addr;
    logic        c_n_z, wr_en_z, busy_z, done_z;
    logic [3:0]  wr_addr_z;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nrs_gold_seq_gen dut (
        .clk(clk), .rst(rst), .start(start), .c_init(c_init), .skip_offset(skip),
        .c_n(c_n), .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done)
    );

    nrs_gold_seq_gen #(.NC(0)) dut_z (
        .clk(clk), .rst(rst), .start(start_z), .c_init(c_init), .skip_offset(skip),
        .c_n(c_n_z), .wr_en(wr_en_z), .wr_addr(wr_addr_z), .busy(busy_z), .done(done_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // c(n0..n0+15) from the x1/x2 recurrences of 36.211, offset by nc
    function automatic logic [15:0] gold16(input logic [30:0] ci, input int n0, input int nc);
        bit a[4096];
        bit b[4096];
        logic [15:0] r;
        for (int i = 0; i < 31; i++) begin
            a[i] = (i == 0);
            b[i] = ci[i];
        end
        for (int m = 31; m <= n0 + nc + 15; m++) begin
            a[m] = a[m-28] ^ a[m-31];
            b[m] = b[m-28] ^ b[m-29] ^ b[m-30] ^ b[m-31];
        end
        for (int j = 0; j < 16; j++) r[j] = a[n0+nc+j] ^ b[n0+nc+j];
        return r;
    endfunction

    // One full run; ghost pulses start mid-GEN and in DONE with a different c_init.
    task automatic do_run(input bit sel, input logic [30:0] ci, input logic [10:0] so,
                          input bit ghost, input bit use_hand, input logic [15:0] hand,
                          input string tag);
        int k, first, dn, nwr, n;
        logic [15:0] got;
        logic ow, oc, ob, od;
        logic [3:0] oa;
        n = (sel ? 0 : 1600) + int'(so);
        @(negedge clk);
        if (sel) start_z = 1'b1; else start = 1'b1;
        c_init = ci;
        skip   = so;
        @(negedge clk);
        start = 1'b0; start_z = 1'b0;
        k = cyc;
        c_init = 31'($urandom);
        skip   = 11'($urandom);
        first = -1; dn = -1; nwr = 0; got = '0;
        for (int t = 0; t < 5000 && dn < 0; t++) begin
            start = 1'b0; start_z = 1'b0;
            ow = sel ? wr_en_z : wr_en;
            oc = sel ? c_n_z : c_n;
            ob = sel ? busy_z : busy;
            od = sel ? done_z : done;
            oa = sel ? wr_addr_z : wr_addr;
            if (t == 0 && n > 0) check({tag, "_warm"}, {29'd0, ow, oc, ob}, 32'b001);
            if (ow) begin
                check({tag, "_addr"}, 32'(oa), 32'(nwr));
                if (first < 0) first = cyc - k;
                if (nwr < 16) got[nwr] = oc;
                nwr++;
                if (ghost && nwr == 8) begin
                    start  = 1'b1;
                    c_init = 31'h7FFF_FFFF;
                    skip   = 11'd0;
                end
            end
            if (od) begin
                dn = cyc - k;
                check({tag, "_idle_out"}, {28'd0, ob, ow, oc, |oa}, 32'd0);
                if (ghost) begin
                    start  = 1'b1;
                    c_init = 31'h0F0F_0F0F;
                end
            end
            if (dn < 0) @(negedge clk);
        end
        check({tag, "_first_wr"}, 32'(first), 32'(n));
        check({tag, "_done_at"}, 32'(dn), 32'(n + 16));
        check({tag, "_nwr"}, 32'(nwr), 32'd16);
        check({tag, "_bits"}, 32'(got), 32'(gold16(ci, int'(so), sel ? 0 : 1600)));
        if (use_hand) check({tag, "_hand"}, 32'(got), 32'(hand));
    endtask

    // Reset during WARMUP (gen_at<0) or at write address gen_at; run must be abandoned.
    task automatic rst_mid(input int gen_at, input string tag);
        int nwr;
        @(negedge clk);
        start  = 1'b1;
        c_init = 31'h1357_9BDF;
        skip   = 11'd0;
        @(negedge clk);
        start = 1'b0;
        if (gen_at < 0) begin
            repeat (100) @(negedge clk);
        end else begin
            for (int t = 0; t < 3000 && !(wr_en && wr_addr == 4'(gen_at)); t++) @(negedge clk);
            check({tag, "_reached"}, {31'd0, wr_en && wr_addr == 4'(gen_at)}, 32'd1);
        end
        rst = 1'b1;
        #1;
        check({tag, "_async"}, {24'd0, c_n, wr_en, wr_addr, busy, done}, 32'd0);
        @(negedge clk);
        check({tag, "_held"}, {24'd0, c_n, wr_en, wr_addr, busy, done}, 32'd0);
        rst = 1'b0;
        nwr = 0;
        for (int t = 0; t < 1700; t++) begin
            @(negedge clk);
            if (wr_en || done || busy) nwr++;
        end
        check({tag, "_quiet"}, 32'(nwr), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_z = 1'b0; c_init = '0; skip = '0;
        repeat (3) @(negedge clk);
        check("reset_main", {24'd0, c_n, wr_en, wr_addr, busy, done}, 32'd0);
        check("reset_nc0", {24'd0, c_n_z, wr_en_z, wr_addr_z, busy_z, done_z}, 32'd0);
        rst = 1'b0;

        do_run(1'b0, 31'h0, 11'd0, 1'b0, 1'b0, 16'h0, "cinit0");
        do_run(1'b0, 31'h0912_2B3C ^ 31'h0008_0000, 11'd218, 1'b0, 1'b0, 16'h0, "skip218");

        do_run(1'b1, 31'h0, 11'd0, 1'b0, 1'b1, 16'h0001, "nc0_zero");
        do_run(1'b1, 31'h1, 11'd0, 1'b0, 1'b1, 16'h0000, "nc0_one");
        do_run(1'b1, 31'h0, 11'd20, 1'b0, 1'b1, 16'h0800, "nc0_skip20");

        do_run(1'b0, 31'h05A5_A5A5, 11'd3, 1'b1, 1'b0, 16'h0, "ghost");
        do_run(1'b0, 31'h0123_4567, 11'd5, 1'b0, 1'b0, 16'h0, "after_done");

        do_run(1'b0, 31'h2AAA_AAAA, 11'd2047, 1'b0, 1'b0, 16'h0, "skipmax");

        rst_mid(-1, "rst_warm");
        rst_mid(5, "rst_gen");
        do_run(1'b0, 31'h0000_4321, 11'd7, 1'b0, 1'b0, 16'h0, "recover");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
